// File: rtl/label_smoother.sv
// Majority-vote smoother for a stream of binary seizure labels, with hysteresis and holdoff.
// Define LABEL_SMOOTHER_EVENT_CNT_EN to add the o_event_count seizure-onset counter.
module label_smoother #(
    parameter int WINDOW     = 8,
    parameter int ON_THRESH  = 6,
    parameter int OFF_THRESH = 2,
    parameter int HOLDOFF    = 4
) (
    input  logic                         i_clk,
    input  logic                         i_nrst,
    input  logic                         i_label_valid,
    input  logic                         i_label_in,
    input  logic                         i_clear,
    output logic [$clog2(WINDOW+1)-1:0]  o_vote_count,
    output logic                         o_alarm,
    output logic                         o_decision_valid,
    output logic [1:0]                   o_state
`ifdef LABEL_SMOOTHER_EVENT_CNT_EN
    ,
    output logic [15:0]                  o_event_count
`endif
);

    localparam int CW = $clog2(WINDOW + 1);
    localparam logic [CW-1:0] WINDOW_C = CW'(WINDOW);
    localparam logic [CW-1:0] ON_C     = CW'(ON_THRESH);
    localparam logic [CW-1:0] OFF_C    = CW'(OFF_THRESH);
    localparam logic [7:0]    HOLD_C   = 8'(HOLDOFF);

    typedef enum logic [1:0] {
        WARMUP   = 2'd0,
        NORMAL   = 2'd1,
        SEIZURE  = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [WINDOW-1:0]   r_hist;
    logic [CW-1:0]       r_fill;
    logic [CW-1:0]       r_count;
    logic [7:0]          r_hold;
    logic                r_alarm;
    logic                r_dv;

    logic                w_accept;
    logic                w_full;
    logic                w_evict;
    logic [CW-1:0]       w_next_count;
    logic [CW-1:0]       w_fill_next;
    logic [7:0]          w_hold_next;

    assign w_accept     = i_label_valid & ~i_clear;
    assign w_full       = (r_fill == WINDOW_C);
    // The oldest bit only leaves the vote once the window has actually been filled.
    assign w_evict      = w_full & r_hist[WINDOW-1];
    assign w_next_count = r_count + CW'(i_label_in) - CW'(w_evict);
    assign w_fill_next  = w_full ? r_fill : r_fill + CW'(1);

    always_ff @(posedge i_clk) begin
        if (!i_nrst || i_clear) begin
            r_state <= WARMUP;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_hold_next  = r_hold;
        if (w_accept) begin
            case (r_state)
                WARMUP: begin
                    if (w_fill_next == WINDOW_C) begin
                        w_next_state = (w_next_count >= ON_C) ? SEIZURE : NORMAL;
                    end
                end
                NORMAL: begin
                    if (w_next_count >= ON_C) begin
                        w_next_state = SEIZURE;
                    end
                end
                SEIZURE: begin
                    if (w_next_count <= OFF_C) begin
                        w_next_state = COOLDOWN;
                        w_hold_next  = HOLD_C;
                    end
                end
                COOLDOWN: begin
                    if (w_next_count >= ON_C) begin
                        w_next_state = SEIZURE;
                    end else begin
                        w_hold_next = r_hold - 8'd1;
                        if (r_hold == 8'd1) begin
                            w_next_state = NORMAL;
                        end
                    end
                end
                default: w_next_state = WARMUP;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst || i_clear) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_count <= '0;
            r_hold  <= '0;
            r_alarm <= 1'b0;
            r_dv    <= 1'b0;
        end else begin
            r_alarm <= (w_next_state == SEIZURE) || (w_next_state == COOLDOWN);
            r_dv    <= w_accept && (w_next_state != WARMUP);
            r_hold  <= w_hold_next;
            if (w_accept) begin
                r_hist  <= {r_hist[WINDOW-2:0], i_label_in};
                r_count <= w_next_count;
                r_fill  <= w_fill_next;
            end
        end
    end

`ifdef LABEL_SMOOTHER_EVENT_CNT_EN
    logic [15:0] r_events;
    logic        w_onset;

    // Only fresh onsets count; bouncing back from COOLDOWN is the same seizure.
    assign w_onset = w_accept && (w_next_state == SEIZURE) &&
                     ((r_state == WARMUP) || (r_state == NORMAL));

    always_ff @(posedge i_clk) begin
        if (!i_nrst || i_clear) begin
            r_events <= '0;
        end else if (w_onset && (r_events != 16'hFFFF)) begin
            r_events <= r_events + 16'd1;
        end
    end

    assign o_event_count = r_events;
`endif

    assign o_vote_count     = r_count;
    assign o_alarm          = r_alarm;
    assign o_decision_valid = r_dv;
    assign o_state          = r_state;

endmodule

// File: tb/tb_label_smoother.sv
// Self-checking bench for label_smoother: directed scenarios plus randomized label streams
// checked against a queue-based reference model of the voting and hysteresis rules.
module tb_label_smoother;

    localparam int WINDOW     = 8;
    localparam int ON_THRESH  = 6;
    localparam int OFF_THRESH = 2;
    localparam int HOLDOFF    = 4;
    localparam int CW         = $clog2(WINDOW + 1);

    logic          clk = 1'b0;
    logic          nrst;
    logic          labelValid;
    logic          labelIn;
    logic          clear;
    logic [CW-1:0] voteCount;
    logic          alarm;
    logic          decisionValid;
    logic [1:0]    state;
`ifdef LABEL_SMOOTHER_EVENT_CNT_EN
    logic [15:0]   eventCount;
`endif

    int compared   = 0;
    int mismatched = 0;

    // Reference model: the window is a plain queue of the last WINDOW labels.
    int q[$];
    int mState;
    int mHold;
    int mEvents;
    int mAlarm;
    int mDv;

    always #5 clk = ~clk;

    label_smoother #(
        .WINDOW(WINDOW), .ON_THRESH(ON_THRESH), .OFF_THRESH(OFF_THRESH), .HOLDOFF(HOLDOFF)
    ) dut (
        .i_clk(clk),
        .i_nrst(nrst),
        .i_label_valid(labelValid),
        .i_label_in(labelIn),
        .i_clear(clear),
        .o_vote_count(voteCount),
        .o_alarm(alarm),
        .o_decision_valid(decisionValid),
        .o_state(state)
`ifdef LABEL_SMOOTHER_EVENT_CNT_EN
        ,
        .o_event_count(eventCount)
`endif
    );

    function automatic int modelCount();
        int s = 0;
        foreach (q[i]) s += q[i];
        return s;
    endfunction

    task automatic modelStep(input bit v, input bit l, input bit c, input bit n);
        int prev;
        int cnt;
        if (!n || c) begin
            q.delete();
            mState = 0; mHold = 0; mEvents = 0; mAlarm = 0; mDv = 0;
            return;
        end
        if (!v) begin
            mDv = 0;
            return;
        end
        q.push_back(int'(l));
        if (q.size() > WINDOW) void'(q.pop_front());
        cnt  = modelCount();
        prev = mState;
        case (prev)
            0: if (q.size() == WINDOW) mState = (cnt >= ON_THRESH) ? 2 : 1;
            1: if (cnt >= ON_THRESH) mState = 2;
            2: if (cnt <= OFF_THRESH) begin mState = 3; mHold = HOLDOFF; end
            default: begin
                if (cnt >= ON_THRESH) mState = 2;
                else begin
                    mHold--;
                    if (mHold == 0) mState = 1;
                end
            end
        endcase
        if (mState == 2 && prev <= 1 && mEvents < 65535) mEvents++;
        mAlarm = (mState >= 2) ? 1 : 0;
        mDv    = (mState != 0) ? 1 : 0;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle on the falling edge, advance the model at the rising edge, compare just after.
    task automatic applyStimulus(input bit v, input bit l, input bit c, input bit n);
        @(negedge clk);
        labelValid = v; labelIn = l; clear = c; nrst = n;
        @(posedge clk);
        modelStep(v, l, c, n);
        #1;
        checkOutput("vote_count", int'(voteCount), modelCount());
        checkOutput("alarm", int'(alarm), mAlarm);
        checkOutput("decision_valid", int'(decisionValid), mDv);
        checkOutput("state", int'(state), mState);
`ifdef LABEL_SMOOTHER_EVENT_CNT_EN
        checkOutput("event_count", int'(eventCount), mEvents);
`endif
    endtask

    task automatic feed(input bit l);
        int gap;
        gap = $urandom_range(0, 5);
        for (int i = 0; i < gap; i++) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        applyStimulus(1'b1, l, 1'b0, 1'b1);
    endtask

    task automatic feedMany(input bit l, input int n);
        for (int i = 0; i < n; i++) feed(l);
    endtask

    task automatic doClear();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        int bias;
        int r;
        nrst = 1'b0; labelValid = 1'b0; labelIn = 1'b0; clear = 1'b0;
        mState = 0; mHold = 0; mEvents = 0; mAlarm = 0; mDv = 0;

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("reset_state", int'(state), 0);
        checkOutput("reset_count", int'(voteCount), 0);
        checkOutput("reset_alarm", int'(alarm), 0);

        // Warm-up: seven ones give nothing, the eighth fills the window straight into seizure.
        feedMany(1'b1, 7);
        checkOutput("warm7_state", int'(state), 0);
        checkOutput("warm7_alarm", int'(alarm), 0);
        feed(1'b1);
        checkOutput("warm8_state", int'(state), 2);
        checkOutput("warm8_count", int'(voteCount), 8);
        checkOutput("warm8_alarm", int'(alarm), 1);
        checkOutput("warm8_dv", int'(decisionValid), 1);

        // Holdoff: six zeros drop to count 2, then four more zeros run out the holdoff.
        feedMany(1'b0, 6);
        checkOutput("hold_enter_state", int'(state), 3);
        checkOutput("hold_enter_count", int'(voteCount), 2);
        feedMany(1'b0, 3);
        checkOutput("hold_mid_state", int'(state), 3);
        checkOutput("hold_mid_alarm", int'(alarm), 1);
        feed(1'b0);
        checkOutput("hold_exit_state", int'(state), 1);
        checkOutput("hold_exit_alarm", int'(alarm), 0);

        // Threshold edge: a one evicting a zero reaches ON, evicting a one does not.
        doClear();
        feed(1'b0); feedMany(1'b1, 5); feedMany(1'b0, 2);
        checkOutput("thr_a_state", int'(state), 1);
        checkOutput("thr_a_count", int'(voteCount), 5);
        feed(1'b1);
        checkOutput("thr_a_count6", int'(voteCount), 6);
        checkOutput("thr_a_alarm", int'(alarm), 1);
        doClear();
        feedMany(1'b1, 5); feedMany(1'b0, 3);
        feed(1'b1);
        checkOutput("thr_b_count", int'(voteCount), 5);
        checkOutput("thr_b_alarm", int'(alarm), 0);

        // Re-trigger from cooldown on the last holdoff label; no new onset is counted.
        doClear();
        feedMany(1'b1, 8);
        feedMany(1'b0, 5); feedMany(1'b1, 2); feed(1'b0);
        checkOutput("retrig_cool_state", int'(state), 3);
        feedMany(1'b1, 3);
        checkOutput("retrig_hold_state", int'(state), 3);
        feed(1'b1);
        checkOutput("retrig_state", int'(state), 2);
`ifdef LABEL_SMOOTHER_EVENT_CNT_EN
        checkOutput("retrig_events", int'(eventCount), 1);
`endif

        // Clear and reset colliding with a valid one in seizure.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("clr_state", int'(state), 0);
        checkOutput("clr_count", int'(voteCount), 0);
        checkOutput("clr_alarm", int'(alarm), 0);
        feedMany(1'b1, 8);
        checkOutput("refill_state", int'(state), 2);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("rst_coll_state", int'(state), 0);
        checkOutput("rst_coll_count", int'(voteCount), 0);
        checkOutput("rst_coll_alarm", int'(alarm), 0);

        // Random label streams with slowly changing bias, idle gaps, occasional clear/reset.
        bias = 50;
        for (int i = 0; i < 800; i++) begin
            if (i % 20 == 0) begin
                r = $urandom_range(0, 2);
                bias = (r == 0) ? 10 : (r == 1) ? 50 : 90;
            end
            r = $urandom_range(0, 199);
            if (r == 0)      applyStimulus(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0);
            else if (r < 3)  applyStimulus(1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b1);
            else             feed(($urandom_range(0, 99) < bias) ? 1'b1 : 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/label_smoother.md
LABEL_SMOOTHER -- requirements
Module: label_smoother

Interface
REQ-001 Parameter WINDOW, default 8: number of most recent accepted labels in the vote window, range 2..64.
REQ-002 Parameter ON_THRESH, default 6: ones-count at or above which a seizure is declared; must satisfy OFF_THRESH < ON_THRESH <= WINDOW.
REQ-003 Parameter OFF_THRESH, default 2: ones-count at or below which a seizure starts ending.
REQ-004 Parameter HOLDOFF, default 4: number of accepted labels the alarm stays asserted after the count falls to OFF_THRESH or below; range 1..255.
REQ-005 clk  input  1  system clock; all logic on the rising edge.
REQ-006 nrst  input  1  synchronous, active-low reset.
REQ-007 label_valid  input  1  qualifies label_in for one cycle; the classifier pulses it one cycle after each op=1 classification.
REQ-008 label_in  input  1  classifier predicted label (1 = seizure, 0 = non-seizure).
REQ-009 clear  input  1  synchronous flush of window and state; takes precedence over label_valid.
REQ-010 vote_count  output  $clog2(WINDOW+1)  number of ones currently held in the window.
REQ-011 alarm  output  1  smoothed seizure decision.
REQ-012 decision_valid  output  1  one-cycle pulse when alarm and vote_count reflect a newly accepted label outside warm-up.
REQ-013 state  output  2  current FSM state encoding, for debug.

Function
REQ-014 Accept a label on every rising edge where label_valid=1 and clear=0; there is no backpressure, and every valid label is consumed.
REQ-015 Accepting a label shifts it into a WINDOW-deep history register; vote_count is updated in the same edge by +label_in minus the evicted bit, and the evicted bit is counted only once the window is full.
REQ-016 vote_count never exceeds WINDOW or drops below 0; equal add and evict leaves it unchanged.
REQ-017 A fill counter saturates at WINDOW; while it is below WINDOW the FSM stays in WARMUP.
REQ-018 FSM states: WARMUP=0, NORMAL=1, SEIZURE=2, COOLDOWN=3.
REQ-019 All transitions are evaluated only on an accepted label, using the post-update count (next_count).
REQ-020 WARMUP -> NORMAL when the accepted label fills the window; if next_count >= ON_THRESH, go directly to SEIZURE.
REQ-021 NORMAL -> SEIZURE when next_count >= ON_THRESH.
REQ-022 SEIZURE -> COOLDOWN when next_count <= OFF_THRESH, loading the holdoff counter with HOLDOFF.
REQ-023 COOLDOWN -> SEIZURE when next_count >= ON_THRESH.
REQ-024 Otherwise in COOLDOWN, each accepted label decrements the holdoff counter; when the counter reaches 0, go to NORMAL.
REQ-025 alarm is registered and equals 1 exactly in SEIZURE and COOLDOWN, so the latency from the accepted edge to alarm is one cycle.
REQ-026 decision_valid is registered high for the cycle after an accepted label, when the post-edge state is not WARMUP.
REQ-027 clear=1 zeroes history, fill counter, vote_count, holdoff counter, alarm and decision_valid, and sets state to WARMUP on that edge; a label presented in the same cycle is discarded.

Reset
REQ-028 On a clk edge with nrst=0, the reset values are: state=WARMUP, history=0, fill=0, vote_count=0, holdoff=0, alarm=0, decision_valid=0, event_count=0 (if present).
REQ-029 Reset asserted mid-operation (any state) behaves identically to clear and overrides clear and label_valid.

Configuration
REQ-030 Macro LABEL_SMOOTHER_EVENT_CNT_EN compiles in the output event_count  output  16  saturating count of entries into SEIZURE from WARMUP or NORMAL only; re-entry from COOLDOWN is not counted.
REQ-031 event_count saturates at 16'hFFFF and is cleared by reset and by clear.
REQ-032 Without the macro, the event_count port and its logic do not exist, and all other behaviour is unchanged.

Verification (defaults WINDOW=8, ON=6, OFF=2, HOLDOFF=4)
REQ-033 Warm-up: 7 accepted 1s -> alarm=0, decision_valid never pulses, state=0; 8th 1 -> next cycle state=2, alarm=1, vote_count=8, decision_valid pulse.
REQ-034 Threshold edge: window filled with 5 ones then one more 1 evicting a 0 -> vote_count=6 and alarm=1 one cycle later; evicting a 1 instead leaves vote_count=5 and alarm=0.
REQ-035 Holdoff: from SEIZURE with count 8, feed 0s -> after the 6th 0 (count=2) state=3; alarm stays 1 for 4 more 0-labels, then state=1 and alarm=0.
REQ-036 Re-trigger: in COOLDOWN with holdoff=2, feed 1s until count=6 -> state=2; with the macro, event_count is unchanged.
REQ-037 Clear/reset collision: clear=1 with label_valid=1, label_in=1 in SEIZURE -> next cycle state=0, vote_count=0, alarm=0, event_count=0; repeat with nrst=0 and get the same result.
REQ-038 Gaps: valid labels separated by 0..5 idle cycles produce results identical to back-to-back labels, and nothing changes on idle cycles.
